svc_rv_scoreboard: RTL and testbench

//  Producer-side hazard tracker for the RV pipeline, complementary to the EX forwarding mux.

---
 rtl/svc_rv_pkg.sv | 15 +
 rtl/svc_rv_sb_cnt.sv | 52 +++++
 rtl/svc_rv_scoreboard.sv | 87 ++++++++
 tb/tb_svc_rv_scoreboard.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_pkg.sv
// Shared RV pipeline constants and register-index helpers.
package svc_rv_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]  reg_vec_t;

  // True when idx selects architectural register r; x0 never matches.
  function automatic logic reg_sel(input reg_idx_t idx, input int unsigned r);
    return (r != 0) && (idx == reg_idx_t'(r));
  endfunction

endpackage

// File: rtl/svc_rv_sb_cnt.sv
// Per-register outstanding-write counter for the hazard scoreboard.
// Saturates at both ends; a decrement at zero is reported as underflow.
module svc_rv_sb_cnt
  import svc_rv_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic one_o,
  output logic max_o,
  output logic underflow_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CntOne);
  assign max_o  = (cnt_q == CntMax);

  // A retire dropped by a simultaneous flush is not an error.
  assign underflow_o = dec_i & ~clr_i & zero_o;

  // Next count: clear wins, matched inc/dec cancel, both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + CntOne;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/svc_rv_scoreboard.sv
// Producer-side hazard tracker beside the ID stage. Records destination registers of
// in-flight instructions whose results cannot be forwarded, from issue until writeback,
// and stalls ID while it reads one of them or would overflow a counter.
module svc_rv_scoreboard
  import svc_rv_pkg::*;
#(
  parameter int unsigned FWD    = 0,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic                 rs1_used_id,
  input  logic                 rs2_used_id,
  input  logic [REG_IDX_W-1:0] rd_id,
  input  logic                 reg_write_id,
  input  logic                 is_long_id,
  input  logic                 issue_id,
  input  logic                 flush_id,
  input  logic [REG_IDX_W-1:0] rd_wb,
  input  logic                 retire_wb,
  input  logic                 flush_all,
  output logic                 stall_id,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 busy,
  output logic                 err
);

  localparam logic TrackAll = (FWD == 0);
  localparam logic Bypass   = (BYPASS != 0);

  logic     track, ret;
  logic     hit1, hit2, full;
  logic     err_q;
  reg_vec_t zero_vec, one_vec, max_vec, uflow_vec;

  assign track = issue_id & ~flush_id & reg_write_id & (rd_id != '0) & (TrackAll | is_long_id);
  assign ret   = retire_wb & (rd_wb != '0);

  // x0 is hardwired: never pending, never full, never underflows.
  assign zero_vec[0]  = 1'b1;
  assign one_vec[0]   = 1'b0;
  assign max_vec[0]   = 1'b0;
  assign uflow_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    svc_rv_sb_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (flush_all),
      .inc_i      (track & reg_sel(rd_id, r)),
      .dec_i      (ret & reg_sel(rd_wb, r)),
      .zero_o     (zero_vec[r]),
      .one_o      (one_vec[r]),
      .max_o      (max_vec[r]),
      .underflow_o(uflow_vec[r])
    );
  end

  // With write-through, the last outstanding write retiring this cycle releases the reader.
  assign hit1 = rs1_used_id & (rs1_id != '0) & ~zero_vec[rs1_id]
              & ~(Bypass & ret & (rd_wb == rs1_id) & one_vec[rs1_id]);
  assign hit2 = rs2_used_id & (rs2_id != '0) & ~zero_vec[rs2_id]
              & ~(Bypass & ret & (rd_wb == rs2_id) & one_vec[rs2_id]);

  // Holding back a writer to a saturated counter guarantees no overflow.
  assign full = reg_write_id & (rd_id != '0) & max_vec[rd_id] & ~(ret & (rd_wb == rd_id));

  assign stall_id = hit1 | hit2 | full;
  assign pending  = ~zero_vec;
  assign busy     = |pending;
  assign err      = err_q;

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|uflow_vec) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Scoreboard bench: four configurations share one stimulus stream; expectations are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_svc_rv_scoreboard;

  localparam int NDUT = 4;  // 0: F1 B1 C2, 1: F1 B0 C2, 2: F0 B1 C2, 3: F1 B1 C1
  localparam int TimeoutCycles = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_wb;
  logic       rs1_used_id, rs2_used_id, reg_write_id, is_long_id;
  logic       issue_id, flush_id, retire_wb, flush_all;

  logic        stall_w [NDUT];
  logic [31:0] pend_w  [NDUT];
  logic        busy_w  [NDUT];
  logic        err_w   [NDUT];

  logic done = 1'b0;

  always #5 clk = ~clk;

  svc_rv_scoreboard #(.FWD(1), .BYPASS(1), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rd_id(rd_id), .reg_write_id(reg_write_id),
    .is_long_id(is_long_id), .issue_id(issue_id), .flush_id(flush_id), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .flush_all(flush_all), .stall_id(stall_w[0]),
    .pending(pend_w[0]), .busy(busy_w[0]), .err(err_w[0]));

  svc_rv_scoreboard #(.FWD(1), .BYPASS(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rd_id(rd_id), .reg_write_id(reg_write_id),
    .is_long_id(is_long_id), .issue_id(issue_id), .flush_id(flush_id), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .flush_all(flush_all), .stall_id(stall_w[1]),
    .pending(pend_w[1]), .busy(busy_w[1]), .err(err_w[1]));

  svc_rv_scoreboard #(.FWD(0), .BYPASS(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rd_id(rd_id), .reg_write_id(reg_write_id),
    .is_long_id(is_long_id), .issue_id(issue_id), .flush_id(flush_id), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .flush_all(flush_all), .stall_id(stall_w[2]),
    .pending(pend_w[2]), .busy(busy_w[2]), .err(err_w[2]));

  svc_rv_scoreboard #(.FWD(1), .BYPASS(1), .CNT_W(1)) u_d (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id),
    .rs2_used_id(rs2_used_id), .rd_id(rd_id), .reg_write_id(reg_write_id),
    .is_long_id(is_long_id), .issue_id(issue_id), .flush_id(flush_id), .rd_wb(rd_wb),
    .retire_wb(retire_wb), .flush_all(flush_all), .stall_id(stall_w[3]),
    .pending(pend_w[3]), .busy(busy_w[3]), .err(err_w[3]));

  typedef struct {
    string       name;
    int          dut;
    logic        stall;
    logic [31:0] pend;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: compare every queued expectation against the selected instance.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      if (stall_w[e.dut] !== e.stall || pend_w[e.dut] !== e.pend ||
          busy_w[e.dut] !== e.busy || err_w[e.dut] !== e.err) begin
        miscompares++;
        $display("FAIL %s dut%0d: got stall=%b pending=%h busy=%b err=%b, want stall=%b pending=%h busy=%b err=%b",
                 e.name, e.dut, stall_w[e.dut], pend_w[e.dut], busy_w[e.dut], err_w[e.dut],
                 e.stall, e.pend, e.busy, e.err);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded number of cycles.
  initial begin : watchdog
    repeat (TimeoutCycles) @(posedge clk);
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: stimulus did not finish within %0d cycles", TimeoutCycles);
      $finish;
    end
  end

  task automatic expect_out(input string name, input int dut, input logic stall,
                            input logic [31:0] pend, input logic err);
    exp_t e;
    e.name  = name;
    e.dut   = dut;
    e.stall = stall;
    e.pend  = pend;
    e.busy  = (pend != 32'd0);
    e.err   = err;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and drop all inputs to idle.
  task automatic nxt();
    @(posedge clk);
    #1;
    rst = 0; rs1_id = 0; rs2_id = 0; rd_id = 0; rd_wb = 0;
    rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0; is_long_id = 0;
    issue_id = 0; flush_id = 0; retire_wb = 0; flush_all = 0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    issue_id = 1; reg_write_id = 1; is_long_id = 1; rd_id = rd;
  endtask

  task automatic read1(input logic [4:0] r);
    rs1_id = r; rs1_used_id = 1;
  endtask

  task automatic retire(input logic [4:0] r);
    retire_wb = 1; rd_wb = r;
  endtask

  task automatic do_reset(input string name);
    nxt();
    rst = 1;
    nxt();
    for (int d = 0; d < NDUT; d++) expect_out(name, d, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1; rs1_id = 0; rs2_id = 0; rd_id = 0; rd_wb = 0;
    rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0; is_long_id = 0;
    issue_id = 0; flush_id = 0; retire_wb = 0; flush_all = 0;
    nxt();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (stall_w[d] !== 1'b0 || pend_w[d] !== 32'h0 || busy_w[d] !== 1'b0 ||
          err_w[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_direct dut%0d: stall=%b pending=%h busy=%b err=%b",
                 d, stall_w[d], pend_w[d], busy_w[d], err_w[d]);
      end
    end
    for (int d = 0; d < NDUT; d++) expect_out("reset", d, 0, 32'h0, 0);

    // Load-use on x5, with and without write-through.
    nxt(); issue_long(5);            expect_out("t1_issue", 0, 0, 32'h0, 0);
    nxt(); read1(5);                 expect_out("t1_use_byp", 0, 1, 32'h20, 0);
                                     expect_out("t1_use_nobyp", 1, 1, 32'h20, 0);
    nxt(); read1(5); retire(5);      expect_out("t1_ret_byp", 0, 0, 32'h20, 0);
                                     expect_out("t1_ret_nobyp", 1, 1, 32'h20, 0);
                                     expect_out("t1_ret_cnt1", 3, 0, 32'h20, 0);
    nxt(); read1(5);                 expect_out("t1_after_nobyp", 1, 0, 32'h0, 0);
                                     expect_out("t1_after_byp", 0, 0, 32'h0, 0);

    // Short ALU producer: tracked only without forwarding.
    nxt(); issue_id = 1; reg_write_id = 1; rd_id = 6;
                                     expect_out("t2_issue", 2, 0, 32'h0, 0);
    nxt(); rs2_id = 6; rs2_used_id = 1;
                                     expect_out("t2_fwd_nostall", 0, 0, 32'h0, 0);
                                     expect_out("t2_nofwd_stall", 2, 1, 32'h40, 0);
    nxt(); rs2_id = 6; rs2_used_id = 1; retire(6);
                                     expect_out("t2_nofwd_ret", 2, 0, 32'h40, 0);
                                     expect_out("t2_fwd_ret", 0, 0, 32'h0, 0);
    nxt();                           expect_out("t2_fwd_uflow", 0, 0, 32'h0, 1);
                                     expect_out("t2_nofwd_clean", 2, 0, 32'h0, 0);
    do_reset("t2_reset");

    // WAW: two loads to x7.
    nxt(); issue_long(7);
    nxt(); issue_long(7);            expect_out("t3_second", 0, 0, 32'h80, 0);
                                     expect_out("t3_full_cnt1", 3, 1, 32'h80, 0);
    nxt(); read1(7); retire(7);      expect_out("t3_ret1_stall", 0, 1, 32'h80, 0);
    nxt(); read1(7);                 expect_out("t3_cnt1_stall", 0, 1, 32'h80, 0);
    nxt(); read1(7); retire(7);      expect_out("t3_ret2_release", 0, 0, 32'h80, 0);
    nxt();                           expect_out("t3_idle", 0, 0, 32'h0, 0);
    do_reset("t3_reset");

    // Full stall with a 1-bit counter.
    nxt(); issue_long(8);            expect_out("t4_issue", 3, 0, 32'h0, 0);
    nxt(); reg_write_id = 1; is_long_id = 1; rd_id = 8;
                                     expect_out("t4_full", 3, 1, 32'h100, 0);
                                     expect_out("t4_notfull_w2", 0, 0, 32'h100, 0);
    nxt(); issue_long(8); retire(8); expect_out("t4_full_ret", 3, 0, 32'h100, 0);
    nxt(); read1(8);                 expect_out("t4_cnt_kept", 3, 1, 32'h100, 0);
                                     expect_out("t4_cnt_kept_w2", 0, 1, 32'h100, 0);
    do_reset("t4_reset");

    // Flushes and underflow.
    nxt(); issue_long(9); flush_id = 1;
                                     expect_out("t5_flush_id", 0, 0, 32'h0, 0);
    nxt();                           expect_out("t5_not_rec", 0, 0, 32'h0, 0);
                                     expect_out("t5_not_rec_nofwd", 2, 0, 32'h0, 0);
    nxt(); issue_long(1);
    nxt(); issue_long(2);            expect_out("t5_pend1", 0, 0, 32'h2, 0);
    nxt(); issue_long(3);            expect_out("t5_pend12", 0, 0, 32'h6, 0);
    nxt(); flush_all = 1; retire(1); read1(2);
                                     expect_out("t5_pend123", 0, 1, 32'he, 0);
    nxt();                           expect_out("t5_flushed", 0, 0, 32'h0, 0);
                                     expect_out("t5_flushed_nofwd", 2, 0, 32'h0, 0);
    nxt(); retire(3);                expect_out("t5_uflow_cyc", 0, 0, 32'h0, 0);
    nxt();                           expect_out("t5_err", 0, 0, 32'h0, 1);

    // Reset in the middle of activity.
    nxt(); issue_long(10);
    nxt(); read1(10); rst = 1;       expect_out("t6_pre_rst", 0, 1, 32'h400, 1);
    nxt(); read1(10);
    for (int d = 0; d < NDUT; d++) expect_out("t6_post_rst", d, 0, 32'h0, 0);

    // x0 is never tracked and never stalls.
    nxt(); issue_id = 1; reg_write_id = 1; is_long_id = 1; rd_id = 0;
                                     expect_out("t6_x0_issue", 2, 0, 32'h0, 0);
    nxt(); read1(0); rs2_id = 0; rs2_used_id = 1; retire(0);
                                     expect_out("t6_x0_read", 0, 0, 32'h0, 0);
                                     expect_out("t6_x0_read_nofwd", 2, 0, 32'h0, 0);
    nxt();                           expect_out("t6_x0_noerr", 0, 0, 32'h0, 0);
                                     expect_out("t6_x0_noerr_nofwd", 2, 0, 32'h0, 0);

    nxt();
    nxt();
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else                  $display("FAIL");
    $finish;
  end

endmodule
